// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch stage.
//
// Owns the program counter, issues word reads to instruction memory over a
// req/ack handshake and hands each fetched instruction (with its PC) to
// decode over a valid/ready handshake. Redirects from execute discard any
// wrong-path fetch: an un-acked request is completed (never withdrawn) and
// its data dropped, then fetch restarts at the redirect target.
//
// Optional feature: define IFETCH_SKID_EN to add a 1-entry skid register,
// which allows one instruction per cycle with a zero-wait memory. Without it
// the stage alternates fetch / hand-off (at most one instruction per 2 cycles).
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   redirect_valid/redirect_pc taken branch/jump from execute (pc[1:0] ignored)
//   imem_req/imem_addr         read request to instruction memory (registered)
//   imem_ack/imem_rdata        read completion and data
//   instr_valid/instr/instr_pc instruction slot presented to decode
//   instr_ready                decode accepts the slot this cycle

module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {IDLE, REQ, FULL, FLUSH} state_t;

    state_t      state;
    logic [31:0] pc;        // next fetch address (redirect target while flushing)
    logic        consume;
    logic [31:0] target;
    logic [31:0] pc_inc;

`ifdef IFETCH_SKID_EN
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
`endif

    assign consume = instr_valid && instr_ready;
    assign target  = {redirect_pc[31:2], 2'b00};
    assign pc_inc  = pc + 32'd4;   // wraps modulo 2^32

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'd0;
`ifdef IFETCH_SKID_EN
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 32'd0;
`endif
        end else begin
            // Slot drains on a transfer unless something below refills it.
            if (consume) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end

            if (redirect_valid) begin
                // Redirect wins over everything: flush slot/skid, retarget pc.
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
                pc          <= target;
`ifdef IFETCH_SKID_EN
                skid_valid  <= 1'b0;
`endif
                if ((state == REQ || state == FLUSH) && !imem_ack) begin
                    // Request still outstanding: keep req/addr stable and
                    // wait for its ack before fetching the target.
                    state <= FLUSH;
                end else begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= target;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                    REQ: begin
                        if (imem_ack) begin
                            pc <= pc_inc;
`ifdef IFETCH_SKID_EN
                            if (!instr_valid || consume) begin
                                // Slot free next cycle: fill it, keep fetching.
                                instr_valid <= 1'b1;
                                instr       <= imem_rdata;
                                instr_pc    <= pc;
                                imem_addr   <= pc_inc;
                            end else begin
                                skid_valid <= 1'b1;
                                skid_instr <= imem_rdata;
                                skid_pc    <= pc;
                                state      <= FULL;
                                imem_req   <= 1'b0;
                            end
`else
                            // Slot is always empty in REQ without a skid.
                            instr_valid <= 1'b1;
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            state       <= FULL;
                            imem_req    <= 1'b0;
`endif
                        end
                    end
                    FULL: begin
                        if (consume) begin
`ifdef IFETCH_SKID_EN
                            if (skid_valid) begin
                                instr_valid <= 1'b1;
                                instr       <= skid_instr;
                                instr_pc    <= skid_pc;
                                skid_valid  <= 1'b0;
                            end
`endif
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                    FLUSH: begin
                        // Wrong-path data is dropped; pc already holds the target.
                        if (imem_ack) begin
                            state     <= REQ;
                            imem_addr <= pc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by a
// randomized run. The reference is transaction level: a memory that returns
// a fixed function of the address, an expected-PC sequence for transfers,
// and handshake stability rules. Skid-dependent expectations follow the
// IFETCH_SKID_EN define.

module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IFETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    ifetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;

    // reference state
    logic [31:0] exp_pc;
    bit          p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_instr, p_pc;
    int          wait_left;

    // stimulus knobs
    int          mem_wait;   // <0: random 0..3 wait cycles per request
    bit          rnd;
    bit          rdy;
    bit          rd_req;
    logic [31:0] rd_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_redir = 0;
        exp_pc = RST_PC;
        wait_left = 0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        rd_req = 1'b0;
    endtask

    // One clock: check outputs at the negedge, then drive this cycle's inputs.
    task automatic cyc;
        @(negedge clk);
        if (p_redir)
            chk("redir_clears_valid", 32'(instr_valid), 32'd0);
        else if (p_valid && !p_ready) begin
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, p_instr);
            chk("stall_pc", instr_pc, p_pc);
        end
        if (p_req && !p_ack) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, p_addr);
        end
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (!instr_valid) chk("nop_when_idle", instr, NOP);
        else              chk("instr_data", instr, mem_data(instr_pc));

        if (rnd) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) begin
                rd_req = 1'b1;
                rd_pc  = $urandom;
            end
        end else begin
            instr_ready = rdy;
        end
        redirect_valid = rd_req;
        redirect_pc    = rd_pc;
        rd_req         = 1'b0;

        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!p_req || p_ack)
                wait_left = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(imem_addr);
            end else begin
                wait_left--;
            end
        end

        if (instr_valid && instr_ready) begin
            chk("xfer_pc", instr_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        p_valid = instr_valid; p_ready = instr_ready; p_redir = redirect_valid;
        p_instr = instr; p_pc = instr_pc;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        int  x0;
        bit  found;
        rnd = 0; rdy = 1; mem_wait = 0; rd_pc = 32'd0;

        // 1: zero-wait stream from reset
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) begin
                chk("first_req", 32'(imem_req), 32'd1);
                chk("first_addr", imem_addr, RST_PC);
            end else begin
                chk("stream_valid", 32'(instr_valid), 32'(SKID || (k % 2 == 0)));
            end
        end

        // 2: decode stalls for 5 cycles after the first valid
        do_reset();
        rdy = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k >= 3) chk("stall_req_low", 32'(imem_req), 32'd0);
            if (k == 6) rdy = 1;
        end
        x0 = n_xfer;
        repeat (8) cyc();
        chk("stall_resume", 32'(n_xfer - x0 >= 3), 32'd1);

        // 3: redirect while request to 0x8000_0004 waits for ack
        do_reset();
        rdy = 1;
        cyc();
        mem_wait = 4;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            cyc();
            found = imem_req && (imem_addr == 32'h8000_0004);
        end
        chk("flush_setup", 32'(found), 32'd1);
        rd_req = 1; rd_pc = 32'h0000_0100;
        cyc();
        for (int k = 2; k <= 4; k++) begin
            cyc();
            chk("flush_req", 32'(imem_req), 32'd1);
            chk("flush_addr", imem_addr, 32'h8000_0004);
            chk("flush_valid", 32'(instr_valid), 32'd0);
        end
        mem_wait = 0;
        cyc();
        chk("flush_tgt_req", 32'(imem_req), 32'd1);
        chk("flush_tgt_addr", imem_addr, 32'h0000_0100);
        chk("flush_tgt_valid", 32'(instr_valid), 32'd0);
        cyc();
        chk("flush_first_valid", 32'(instr_valid), 32'd1);
        chk("flush_first_pc", instr_pc, 32'h0000_0100);

        // 4: redirect in the same cycle as the ack
        do_reset();
        rd_req = 1; rd_pc = 32'h0000_0200;
        cyc();
        cyc();
        chk("ackredir_addr", imem_addr, 32'h0000_0200);
        chk("ackredir_req", 32'(imem_req), 32'd1);
        cyc();
        chk("ackredir_valid", 32'(instr_valid), 32'd1);
        chk("ackredir_pc", instr_pc, 32'h0000_0200);

        // 5: redirect near the top of the address space, pc wraps
        do_reset();
        rd_req = 1; rd_pc = 32'hFFFF_FFFE;
        cyc();
        cyc();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_first_pc", instr_pc, 32'hFFFF_FFFC);
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            cyc();
            found = instr_valid && (instr_pc == 32'h0000_0000);
        end
        chk("wrap_zero_seen", 32'(found), 32'd1);

        // 6: async reset between edges while a request is outstanding
        do_reset();
        mem_wait = 3;
        cyc();
        chk("areset_setup", 32'(imem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_req", 32'(imem_req), 32'd0);
        chk("areset_valid", 32'(instr_valid), 32'd0);
        chk("areset_instr", instr, NOP);
        chk("areset_addr", imem_addr, RST_PC);
        mem_wait = 0;
        do_reset();
        cyc();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, RST_PC);

        // 7: random ready, redirects and memory wait states
        do_reset();
        rnd = 1; mem_wait = -1;
        x0 = n_xfer;
        repeat (3000) cyc();
        chk("random_progress", 32'(n_xfer - x0 > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of the control decoder: it owns the program counter and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction, with its PC, to decode over a valid/ready handshake. It accepts branch/jump redirects from execute and discards any wrong-path fetch that is in flight.

## Interface

- `RESET_PC`, default 32'h8000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instr` while no instruction is valid.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `redirect_valid` in 1: one-cycle pulse from execute for a taken branch or jump.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `imem_req` out 1: memory read request.
- `imem_addr` out 32: word-aligned read address.
- `imem_ack` in 1: read complete; `imem_rdata` valid this cycle.
- `imem_rdata` in 32: read data.
- `instr_valid` out 1: `instr`/`instr_pc` hold a valid instruction.
- `instr` out 32: instruction to decode.
- `instr_pc` out 32: address of `instr`.
- `instr_ready` in 1: decode accepts the instruction this cycle.

## Operation

- Reset values:
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=`NOP_INSTR`, `instr_pc`=0.
  - Internal: `pc`=`RESET_PC`, state=IDLE, skid empty.
- States:
  - IDLE: first cycle after reset release. Always goes to REQ.
  - REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`, load the output slot with `instr`=`imem_rdata` and `instr_pc`=`pc`, and set `pc`<=`pc`+4. Then go to FULL, or stay in REQ per Configuration.
  - FULL: `imem_req`=0. When `instr_valid`&&`instr_ready`, go to REQ.
  - FLUSH: a redirect arrived while a request was un-acked. `imem_req`=1 with the old address. On `imem_ack`, drop the data and go to REQ at the redirect target.
- Memory rule: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1. A request is never withdrawn.
- Decode handshake: transfer occurs when `instr_valid`&&`instr_ready`. While stalled, `instr` and `instr_pc` are held stable.
- Redirect has priority over everything else in the same cycle:
  - Output slot and skid are cleared, so `instr_valid`=0 next cycle, even if `instr_ready`=1 this cycle.
  - `pc`<=`{redirect_pc[31:2],2'b00}`.
  - From REQ with no ack this cycle: go to FLUSH.
  - From REQ with ack in the same cycle: drop the data, go to REQ at the target.
  - From IDLE or FULL: go to REQ at the target.
  - In FLUSH: the target is updated to the newest redirect; stay in FLUSH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset asserted mid-operation: all state and outputs go to reset values immediately. The outstanding memory transaction is abandoned.

## Timing

- Latency: with a zero-wait memory (`imem_ack` in the same cycle as `imem_req`), `instr_valid` rises the cycle after the ack.
- Reset to first request: first `imem_req` occurs 2 cycles after reset deassertion (IDLE, then REQ).
- Redirect to new request: first request to the target occurs the cycle after the redirect, or the cycle after the pending ack if FLUSH was entered.
- Throughput without skid: at most 1 instruction per 2 cycles.
- Throughput with skid: 1 instruction per cycle.

## Configuration

- `IFETCH_SKID_EN` defined:
  - Adds a 1-entry skid register.
  - On ack in REQ: data goes to the output slot if it is empty or consumed this cycle; otherwise it goes to the skid.
  - Stay in REQ if the skid will be empty next cycle; otherwise go to FULL.
  - In FULL: when the slot is consumed, the skid moves into the slot and the state goes to REQ.
  - Redirect clears the skid.
- `IFETCH_SKID_EN` undefined: there is no skid. REQ always goes to FULL on ack.

## Test plan

- Reset release, zero-wait memory, `instr_ready`=1:
  - Addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 in order.
  - `instr_valid` every cycle with skid, every other cycle without.
- `instr_ready`=0 for 5 cycles after first valid:
  - `instr`/`instr_pc` stable.
  - `imem_req` low once slot (and skid) are full.
  - No instruction lost or duplicated after release.
- Redirect to 0x0000_0100 while a request to 0x8000_0004 waits 3 cycles for ack:
  - Address held at 0x8000_0004 until ack; its data dropped.
  - Next request is to 0x0000_0100; `instr_valid`=0 throughout.
- Redirect in the same cycle as ack:
  - Acked data never appears on `instr`.
  - Next cycle `imem_addr`=target.
- Redirect to 0xFFFF_FFFE:
  - Fetch at 0xFFFF_FFFC, then 0x0000_0000.
- `reset` asserted between clock edges during REQ:
  - `imem_req`=0, `instr_valid`=0, `instr`=0x0000_0013 immediately.
  - After release, fetch restarts at 0x8000_0000.
